// File: rtl/dmem_portb_reader_if.sv
// Bus bundle for the DMEM port-B read engine: command, memory port and output stream.
// The slave modport is the engine; master is the host/memory/consumer side.
interface dmem_portb_reader_if #(
   parameter int AW = 8,
   parameter int DW = 64
);
   logic          start;
   logic [AW-1:0] base_addr;
   logic [AW:0]   word_count;
   logic          abort;
   logic [AW-1:0] addrb;
   logic [DW-1:0] doutb;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic          out_last;
   logic          out_ready;
   logic          busy;
   logic          done;

   modport master (
      output start, base_addr, word_count, abort, doutb, out_ready,
      input  addrb, out_valid, out_data, out_last, busy, done
   );

   modport slave (
      input  start, base_addr, word_count, abort, doutb, out_ready,
      output addrb, out_valid, out_data, out_last, busy, done
   );
endinterface

// File: rtl/dmem_portb_reader.sv
// Streams a block of DMEM words out of port B over valid/ready, hiding the read latency
// with a small tagged in-flight pipeline and an (RD_LAT+1)-entry output buffer.
module dmem_portb_reader #(
   parameter int AW     = 8,
   parameter int DW     = 64,
   parameter int RD_LAT = 1
) (
   input logic                   clk,
   input logic                   rst,
   dmem_portb_reader_if.slave    bus
);
   localparam int D  = RD_LAT + 1;
   localparam int PW = $clog2(D);
   localparam int CW = $clog2(D + 1);

   typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

   state_t            state;
   logic [RD_LAT-1:0] tag_v;
   logic [RD_LAT-1:0] tag_last;
   logic [RD_LAT-1:0] tag_v_next;
   logic [DW-1:0]     buf_data [D];
   logic [D-1:0]      buf_last;
   logic [PW-1:0]     rd_ptr;
   logic [PW-1:0]     wr_ptr;
   logic [CW-1:0]     count;
   logic [CW-1:0]     in_flight;
   logic [AW:0]       issue_left;
   logic              pop;
   logic              capture;
   logic              issue;
   logic              flush;
   logic              drained;
   logic              last_issue;

   function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
      return (int'(p) == D - 1) ? '0 : p + PW'(1);
   endfunction

   always_comb begin
      in_flight = '0;
      for (int i = 0; i < RD_LAT; i++) in_flight = in_flight + CW'(tag_v[i]);
   end

   assign pop        = bus.out_valid && bus.out_ready;
   assign capture    = tag_v[RD_LAT-1];
   assign flush      = bus.abort && (state == READ || state == DRAIN);
   // A pop on this same edge frees a slot, which is what sustains one word per cycle.
   assign issue      = (state == READ) && !bus.abort &&
                       (int'(count) + int'(in_flight) < D + int'(pop));
   assign last_issue = issue && (issue_left == (AW+1)'(1));
   assign tag_v_next = (tag_v << 1) | RD_LAT'(issue);
   assign drained    = (tag_v_next == '0) &&
                       (int'(count) + int'(capture) - int'(pop) == 0);

   assign bus.out_valid = (count != '0);
   assign bus.out_data  = buf_data[rd_ptr];
   assign bus.out_last  = bus.out_valid && buf_last[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tag_v    <= '0;
         tag_last <= '0;
         buf_last <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         for (int i = 0; i < D; i++) buf_data[i] <= '0;
      end else if (flush) begin
         tag_v    <= '0;
         tag_last <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
      end else begin
         tag_v    <= tag_v_next;
         tag_last <= (tag_last << 1) | RD_LAT'(last_issue);
         if (capture) begin
            buf_data[wr_ptr] <= bus.doutb;
            buf_last[wr_ptr] <= tag_last[RD_LAT-1];
            wr_ptr           <= wrap_inc(wr_ptr);
         end
         if (pop) rd_ptr <= wrap_inc(rd_ptr);
         if (capture && !pop)      count <= count + CW'(1);
         else if (!capture && pop) count <= count - CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         bus.addrb  <= '0;
         issue_left <= '0;
         bus.busy   <= 1'b0;
         bus.done   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               bus.done <= 1'b0;
               if (bus.start) begin
                  bus.addrb  <= bus.base_addr;
                  issue_left <= bus.word_count;
                  if (bus.word_count == '0) begin
                     state    <= DONE;
                     bus.done <= 1'b1;
                  end else begin
                     state    <= READ;
                     bus.busy <= 1'b1;
                  end
               end
            end
            READ: begin
               if (bus.abort) begin
                  state    <= DONE;
                  bus.busy <= 1'b0;
                  bus.done <= 1'b1;
               end else if (issue) begin
                  bus.addrb  <= bus.addrb + AW'(1);
                  issue_left <= issue_left - (AW+1)'(1);
                  if (last_issue) state <= DRAIN;
               end
            end
            DRAIN: begin
               if (bus.abort || drained) begin
                  state    <= DONE;
                  bus.busy <= 1'b0;
                  bus.done <= 1'b1;
               end
            end
            DONE: begin
               state    <= IDLE;
               bus.done <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
